xbar_sched: RTL and testbench

//  Control half of the 4x4 switch crossbar. Scans input FIFOs 0..3 round-robin
//  and reads dest from each head word, bits [9:8]. Skips sources whose output

---
 rtl/xbar_sched.sv | 141 ++++++++++++++
 tb/tb_xbar_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_sched.sv
// Control half of a 4x4 switch crossbar: round-robin scan of four input FIFOs,
// grants one word per two cycles to a source whose destination output FIFO has room.
module xbar_sched #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        fifo_empty,
   input  logic [DATA_W-1:0] fifo0_out,
   input  logic [DATA_W-1:0] fifo1_out,
   input  logic [DATA_W-1:0] fifo2_out,
   input  logic [DATA_W-1:0] fifo3_out,
   input  logic [3:0]        fifo_afull,
   output logic [1:0]        demux0,
   output logic [1:0]        dest,
   output logic [3:0]        pop,
   output logic [3:0]        push,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1,
   output logic [CNT_W-1:0]  pkt_cnt2,
   output logic [CNT_W-1:0]  pkt_cnt3
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t            state_q, state_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [1:0]        demux0_q, demux0_d;
   logic [1:0]        dest_q, dest_d;
   logic [3:0]        pop_q, pop_d;
   logic [3:0]        push_q, push_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q [4];
   logic [CNT_W-1:0]  cnt_d [4];

   logic [1:0]        head_dest [4];
   logic [3:0]        elig;
   logic              found;
   logic [1:0]        winner;
   logic [1:0]        idx;

   // The payload bits pass through the datapath; only the dest field is inspected here.
   logic              unused_payload;
   assign unused_payload = ^{fifo0_out[DATA_W-3:0], fifo1_out[DATA_W-3:0],
                             fifo2_out[DATA_W-3:0], fifo3_out[DATA_W-3:0]};

   assign head_dest[0] = fifo0_out[DATA_W-1:DATA_W-2];
   assign head_dest[1] = fifo1_out[DATA_W-1:DATA_W-2];
   assign head_dest[2] = fifo2_out[DATA_W-1:DATA_W-2];
   assign head_dest[3] = fifo3_out[DATA_W-1:DATA_W-2];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         elig[i] = !fifo_empty[i] && !fifo_afull[head_dest[i]];
      end
   end

   // First eligible source at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      found  = 1'b0;
      winner = 2'd0;
      idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!found && elig[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      demux0_d = demux0_q;
      dest_d   = dest_q;
      pop_d    = 4'b0000;
      push_d   = 4'b0000;
      busy_d   = 1'b0;
      for (int j = 0; j < 4; j++) begin
         cnt_d[j] = cnt_q[j];
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               demux0_d = winner;
               dest_d   = head_dest[winner];
               pop_d    = 4'b0001 << winner;
               push_d   = 4'b0001 << head_dest[winner];
               busy_d   = 1'b1;
               state_d  = XFER;
            end
         end
         XFER: begin
            rr_ptr_d      = demux0_q + 2'd1;
            cnt_d[dest_q] = cnt_q[dest_q] + CNT_W'(1);
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= 2'd0;
         demux0_q <= 2'd0;
         dest_q   <= 2'd0;
         pop_q    <= 4'b0000;
         push_q   <= 4'b0000;
         busy_q   <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            cnt_q[j] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         demux0_q <= demux0_d;
         dest_q   <= dest_d;
         pop_q    <= pop_d;
         push_q   <= push_d;
         busy_q   <= busy_d;
         for (int j = 0; j < 4; j++) begin
            cnt_q[j] <= cnt_d[j];
         end
      end
   end

   assign demux0   = demux0_q;
   assign dest     = dest_q;
   assign pop      = pop_q;
   assign push     = push_q;
   assign busy     = busy_q;
   assign pkt_cnt0 = cnt_q[0];
   assign pkt_cnt1 = cnt_q[1];
   assign pkt_cnt2 = cnt_q[2];
   assign pkt_cnt3 = cnt_q[3];

endmodule

// File: tb/tb_xbar_sched.sv
// Bench for xbar_sched: queue-backed input FIFOs and a transaction-level
// scheduler model, with directed scenarios followed by a randomized run.
module tb_xbar_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] fifo_empty;
   logic [9:0] fifo0_out, fifo1_out, fifo2_out, fifo3_out;
   logic [3:0] fifo_afull;
   logic [1:0] demux0, dest;
   logic [3:0] pop, push;
   logic       busy;
   logic [7:0] pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3;

   xbar_sched #(.DATA_W(10), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
      .fifo0_out(fifo0_out), .fifo1_out(fifo1_out),
      .fifo2_out(fifo2_out), .fifo3_out(fifo3_out),
      .fifo_afull(fifo_afull), .demux0(demux0), .dest(dest),
      .pop(pop), .push(push), .busy(busy),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
      .pkt_cnt2(pkt_cnt2), .pkt_cnt3(pkt_cnt3)
   );

   always #5 clk = ~clk;

   logic [9:0] q0[$], q1[$], q2[$], q3[$];
   int  checks = 0;
   int  passes = 0;
   bit  random_mode = 1'b0;

   // Reference model: state visible after the next rising edge.
   bit         m_busy;
   int         m_rr, m_demux, m_dest;
   logic [3:0] m_pop, m_push;
   int         m_cnt [4];

   function automatic int qsize(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [9:0] qhead(input int i);
      case (i)
         0: return q0[0];
         1: return q1[0];
         2: return q2[0];
         default: return q3[0];
      endcase
   endfunction

   task automatic qpush(input int i, input logic [9:0] w);
      case (i)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   task automatic qpop(input int i);
      case (i)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         2: void'(q2.pop_front());
         default: void'(q3.pop_front());
      endcase
   endtask

   task automatic qclear();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic driveHeads();
      fifo_empty = 4'b0000;
      for (int i = 0; i < 4; i++) fifo_empty[i] = (qsize(i) == 0);
      fifo0_out = (q0.size() > 0) ? q0[0] : 10'($urandom);
      fifo1_out = (q1.size() > 0) ? q1[0] : 10'($urandom);
      fifo2_out = (q2.size() > 0) ? q2[0] : 10'($urandom);
      fifo3_out = (q3.size() > 0) ? q3[0] : 10'($urandom);
   endtask

   task automatic modelStep();
      logic [9:0] h;
      int d;
      if (reset) begin
         m_busy = 0; m_rr = 0; m_demux = 0; m_dest = 0;
         m_pop = 4'b0; m_push = 4'b0;
         for (int j = 0; j < 4; j++) m_cnt[j] = 0;
      end else if (m_busy) begin
         m_rr = (m_demux + 1) % 4;
         m_cnt[m_dest] = (m_cnt[m_dest] + 1) % 256;
         m_pop = 4'b0; m_push = 4'b0; m_busy = 0;
      end else begin
         m_pop = 4'b0; m_push = 4'b0;
         for (int k = 0; k < 4; k++) begin
            int s;
            s = (m_rr + k) % 4;
            if (!m_busy && qsize(s) > 0) begin
               h = qhead(s);
               d = int'(h[9:8]);
               if (!fifo_afull[d]) begin
                  m_busy = 1; m_demux = s; m_dest = d;
                  m_pop[s] = 1'b1; m_push[d] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus();
      driveHeads();
      modelStep();
      @(negedge clk);
      checkOutput("demux0", 32'(demux0), 32'(m_demux));
      checkOutput("dest", 32'(dest), 32'(m_dest));
      checkOutput("pop", 32'(pop), 32'(m_pop));
      checkOutput("push", 32'(push), 32'(m_push));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt[0]));
      checkOutput("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt[1]));
      checkOutput("pkt_cnt2", 32'(pkt_cnt2), 32'(m_cnt[2]));
      checkOutput("pkt_cnt3", 32'(pkt_cnt3), 32'(m_cnt[3]));
      checkOutput("pop_onehot0", 32'($onehot0(pop)), 32'd1);
      checkOutput("push_onehot0", 32'($onehot0(push)), 32'd1);
      checkOutput("pop_push_pair", 32'((pop != 0) == (push != 0)), 32'd1);
      for (int i = 0; i < 4; i++) if (m_pop[i]) qpop(i);
      if (random_mode) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 2) == 0 && qsize(i) < 4) qpush(i, 10'($urandom));
         for (int i = 0; i < 4; i++) fifo_afull[i] = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 199) == 0);
      end
   endtask

   task automatic waitGrant(input string tag, output int src, output int cycles);
      bit seen;
      seen = 0; src = -1; cycles = 0;
      for (int n = 0; n < 12 && !seen; n++) begin
         applyStimulus();
         cycles++;
         if (pop != 0) begin
            seen = 1;
            src = int'(demux0);
         end
      end
      if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic resetWith(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int src, cyc;
      int grants [5];
      int gcyc [5];
      int ng, t;
      reset = 1'b1;
      fifo_afull = 4'b0000;
      m_busy = 0; m_rr = 0; m_demux = 0; m_dest = 0; m_pop = 0; m_push = 0;
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;

      // Reset with all FIFOs loaded; first grant goes to source 0.
      for (int i = 0; i < 4; i++) qpush(i, {2'(3 - i), 8'h5A});
      resetWith(2);
      checkOutput("t1_pop", 32'(pop), 32'd0);
      checkOutput("t1_push", 32'(push), 32'd0);
      checkOutput("t1_demux0", 32'(demux0), 32'd0);
      checkOutput("t1_dest", 32'(dest), 32'd0);
      checkOutput("t1_cnts", 32'({pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3}), 32'd0);
      reset = 1'b0;
      waitGrant("t1", src, cyc);
      checkOutput("t1_first_src", 32'(src), 32'd0);
      checkOutput("t1_latency", 32'(cyc), 32'd1);

      // Single word 0x2AA from source 0.
      qclear();
      resetWith(2);
      qpush(0, 10'h2AA);
      reset = 1'b0;
      applyStimulus();
      checkOutput("t2_demux0", 32'(demux0), 32'd0);
      checkOutput("t2_dest", 32'(dest), 32'd2);
      checkOutput("t2_pop", 32'(pop), 32'b0001);
      checkOutput("t2_push", 32'(push), 32'b0100);
      applyStimulus();
      checkOutput("t2_cnt2", 32'(pkt_cnt2), 32'd1);

      // All heads valid: grants 0,1,2,3,0 two cycles apart.
      qclear();
      resetWith(2);
      for (int i = 0; i < 4; i++) qpush(i, {2'(i), 8'h33});
      qpush(0, 10'h011);
      reset = 1'b0;
      ng = 0;
      for (int n = 0; n < 20 && ng < 5; n++) begin
         applyStimulus();
         if (pop != 0) begin
            grants[ng] = int'(demux0);
            gcyc[ng] = n;
            ng++;
         end
      end
      checkOutput("t3_grant_count", 32'(ng), 32'd5);
      for (int g = 0; g < ng && g < 5; g++) begin
         checkOutput($sformatf("t3_grant%0d", g), 32'(grants[g]), 32'(g % 4));
         if (g > 0) checkOutput($sformatf("t3_spacing%0d", g), 32'(gcyc[g] - gcyc[g-1]), 32'd2);
      end

      // Blocked source does not stall others.
      qclear();
      resetWith(2);
      qpush(0, 10'h155);
      qpush(1, 10'h3AA);
      fifo_afull = 4'b0010;
      reset = 1'b0;
      waitGrant("t4a", src, cyc);
      checkOutput("t4_src1_first", 32'(src), 32'd1);
      for (int n = 0; n < 4; n++) begin
         applyStimulus();
         if (n > 0) checkOutput("t4_src0_held", 32'(pop), 32'd0);
      end
      fifo_afull = 4'b0000;
      waitGrant("t4b", src, cyc);
      checkOutput("t4_src0_after", 32'(src), 32'd0);

      // Reset mid-XFER returns rr_ptr to 0.
      qclear();
      resetWith(2);
      qpush(1, 10'h001); qpush(1, 10'h002); qpush(2, 10'h003);
      reset = 1'b0;
      waitGrant("t5a", src, cyc);
      checkOutput("t5_first", 32'(src), 32'd1);
      reset = 1'b1;
      applyStimulus();
      checkOutput("t5_pop", 32'(pop), 32'd0);
      checkOutput("t5_push", 32'(push), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_cnt0", 32'(pkt_cnt0), 32'd0);
      reset = 1'b0;
      waitGrant("t5b", src, cyc);
      checkOutput("t5_rr_reset", 32'(src), 32'd1);

      // pkt_cnt0 wraps after 256 words.
      qclear();
      resetWith(2);
      for (int w = 0; w < 255; w++) qpush(w % 4, {2'b00, 8'(w)});
      reset = 1'b0;
      for (int n = 0; n < 520; n++) applyStimulus();
      checkOutput("t6_cnt255", 32'(pkt_cnt0), 32'd255);
      qpush(3, 10'h0FF);
      for (int n = 0; n < 4; n++) applyStimulus();
      checkOutput("t6_wrap", 32'(pkt_cnt0), 32'd0);

      // Randomized traffic, afull and occasional reset.
      qclear();
      resetWith(2);
      reset = 1'b0;
      random_mode = 1'b1;
      t = 3000;
      for (int n = 0; n < t; n++) applyStimulus();
      random_mode = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
